serial_port: RTL and testbench

- Full Game Boy serial link port (SB at 0xFF01, SC at 0xFF02) replacing the dummy serial responder.
- Real 8-bit shift register, internal or external bit clock, optional CGB fast-clock mode, SI/SO/SCK pins.
- Sits on the CPU I/O bus beside timer/PPU; raises a level interrupt request held until the interrupt controller acknowledges it.

---
 rtl/serial_pkg.sv | 8 +
 rtl/serial_clk_gen.sv | 75 +++++++
 rtl/serial_port.sv | 128 ++++++++++++
 tb/tb_serial_port.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial link port: register addresses and SC bit positions.
package serial_pkg;
    localparam logic [15:0] SB_ADDR   = 16'hFF01;
    localparam logic [15:0] SC_ADDR   = 16'hFF02;
    localparam int          SC_START  = 7;
    localparam int          SC_SPEED  = 1;
    localparam int          SC_CLKSEL = 0;
endpackage

// File: rtl/serial_clk_gen.sv
// Bit-clock generation for the serial port: internal divider or synchronised external SCK,
// producing one-cycle fall/rise strobes for the shifter.
module serial_clk_gen #(
    parameter int CLK_DIV     = 512,
    parameter int FAST_DIV    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_clksel,
    input  logic i_fast,
    input  logic i_restart,
    input  logic i_sck_in,
    output logic o_fall,
    output logic o_rise,
    output logic o_sck_out
);
    localparam int DIV_MAX = (CLK_DIV > FAST_DIV) ? CLK_DIV : FAST_DIV;
    localparam int DIV_W   = $clog2(DIV_MAX);

    logic [DIV_W-1:0]       r_div;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic                   r_sck_prev;
    logic                   r_sck_out;
    logic [DIV_W-1:0]       w_div_last;
    logic [DIV_W-1:0]       w_div_half;
    logic                   w_int_run;
    logic                   w_ext_run;
    logic                   w_sck_cur;
    logic                   w_int_fall;
    logic                   w_int_rise;

    assign w_div_last = i_fast ? DIV_W'(FAST_DIV - 1) : DIV_W'(CLK_DIV - 1);
    assign w_div_half = i_fast ? DIV_W'(FAST_DIV / 2) : DIV_W'(CLK_DIV / 2);
    assign w_int_run  = i_active && i_clksel;
    assign w_ext_run  = i_active && !i_clksel;
    assign w_sck_cur  = r_sck_sync[SYNC_STAGES-1];

    assign w_int_fall = w_int_run && (r_div == '0);
    assign w_int_rise = w_int_run && (r_div == w_div_half);

    assign o_fall    = w_int_fall || (w_ext_run && r_sck_prev && !w_sck_cur);
    assign o_rise    = w_int_rise || (w_ext_run && !r_sck_prev && w_sck_cur);
    assign o_sck_out = r_sck_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div      <= '0;
            r_sck_sync <= '1;
            r_sck_prev <= 1'b1;
            r_sck_out  <= 1'b1;
        end else begin
            r_sck_sync[0] <= i_sck_in;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sck_sync[i] <= r_sck_sync[i-1];
            r_sck_prev <= w_sck_cur;

            if (i_restart || !w_int_run)
                r_div <= '0;
            else if (r_div == w_div_last)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            // SCK only leaves high while the internal clock is actually shifting
            if (i_restart || !w_int_run)
                r_sck_out <= 1'b1;
            else if (w_int_fall)
                r_sck_out <= 1'b0;
            else if (w_int_rise)
                r_sck_out <= 1'b1;
        end
    end
endmodule

// File: rtl/serial_port.sv
// Game Boy serial link port: SB/SC registers, 8-bit shifter, bus decode and
// level interrupt request held until acknowledged.
module serial_port
    import serial_pkg::*;
#(
    parameter int CLK_DIV     = 512,
    parameter int FAST_DIV    = 16,
    parameter int CGB_MODE    = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    input  logic        rd,
    input  logic        wr,
    output logic        int_serial_req,
    input  logic        int_serial_ack,
    input  logic        sck_in,
    output logic        sck_out,
    output logic        sck_oe,
    input  logic        sin,
    output logic        sout
);
    logic [7:0]             r_sb;
    logic                   r_start;
    logic                   r_speed;
    logic                   r_clksel;
    logic [3:0]             r_count;
    logic                   r_req;
    logic                   r_sout;
    logic [SYNC_STAGES-1:0] r_sin_sync;

    logic w_wr_sb;
    logic w_wr_sc;
    logic w_active;
    logic w_fast;
    logic w_speed_rd;
    logic w_fall;
    logic w_rise;
    logic w_shift_ok;
    logic w_done;
    logic w_sck_out;

    assign w_wr_sb    = wr && (a == SB_ADDR);
    assign w_wr_sc    = wr && (a == SC_ADDR);
    assign w_active   = (r_count != 4'd0);
    assign w_fast     = (CGB_MODE != 0) && r_speed;
    assign w_speed_rd = (CGB_MODE != 0) ? r_speed : 1'b1;
    // A CPU write on the same edge as a shift edge wins; the shift is lost.
    assign w_shift_ok = !(w_wr_sb || w_wr_sc);
    assign w_done     = w_shift_ok && w_rise && (r_count == 4'd1);

    serial_clk_gen #(
        .CLK_DIV     (CLK_DIV),
        .FAST_DIV    (FAST_DIV),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .i_active  (w_active),
        .i_clksel  (r_clksel),
        .i_fast    (w_fast),
        .i_restart (w_wr_sc),
        .i_sck_in  (sck_in),
        .o_fall    (w_fall),
        .o_rise    (w_rise),
        .o_sck_out (w_sck_out)
    );

    assign sck_out        = w_sck_out;
    assign sck_oe         = r_clksel;
    assign sout           = r_sout;
    assign int_serial_req = r_req;

    // Bus idles high when not being read.
    always_comb begin
        dout = 8'hFF;
        if (rd) begin
            case (a)
                SB_ADDR: dout = r_sb;
                SC_ADDR: dout = {r_start, 5'b11111, w_speed_rd, r_clksel};
                default: dout = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb       <= 8'h00;
            r_start    <= 1'b0;
            r_speed    <= 1'b0;
            r_clksel   <= 1'b0;
            r_count    <= 4'd0;
            r_req      <= 1'b0;
            r_sout     <= 1'b1;
            r_sin_sync <= '0;
        end else begin
            r_sin_sync[0] <= sin;
            for (int i = 1; i < SYNC_STAGES; i++)
                r_sin_sync[i] <= r_sin_sync[i-1];

            if (w_shift_ok && w_fall)
                r_sout <= r_sb[7];
            if (w_shift_ok && w_rise) begin
                r_sb    <= {r_sb[6:0], r_sin_sync[SYNC_STAGES-1]};
                r_count <= r_count - 4'd1;
                if (r_count == 4'd1)
                    r_start <= 1'b0;
            end

            if (w_wr_sb)
                r_sb <= din;
            if (w_wr_sc) begin
                r_start  <= din[SC_START];
                r_speed  <= din[SC_SPEED];
                r_clksel <= din[SC_CLKSEL];
                r_count  <= din[SC_START] ? 4'd8 : 4'd0;
            end

            if (w_done)
                r_req <= 1'b1;
            else if (int_serial_ack)
                r_req <= 1'b0;
        end
    end
endmodule

// File: tb/tb_serial_port.sv
// Randomised self-checking bench for serial_port: a DMG-style instance (CLK_DIV=8) and
// a CGB instance (FAST_DIV=4) checked against transfer-level expectations.
module tb_serial_port;
    localparam int DIV  = 8;
    localparam int FDIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a   = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        rd  = 1'b0;

    logic       wr_n = 0, ack_n = 0, sck_in_n = 1, sin_drv = 1, loopb = 0;
    logic [7:0] dout_n;
    logic       req_n, sck_out_n, sck_oe_n, sout_n, sin_n;

    logic       wr_c = 0, ack_c = 0, sin_c = 1;
    logic [7:0] dout_c;
    logic       req_c, sck_out_c, sck_oe_c, sout_c;

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int t0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sin_n = loopb ? sout_n : sin_drv;

    serial_port #(.CLK_DIV(DIV), .FAST_DIV(FDIV), .CGB_MODE(0), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .a(a), .dout(dout_n), .din(din), .rd(rd), .wr(wr_n),
        .int_serial_req(req_n), .int_serial_ack(ack_n), .sck_in(sck_in_n),
        .sck_out(sck_out_n), .sck_oe(sck_oe_n), .sin(sin_n), .sout(sout_n));

    serial_port #(.CLK_DIV(DIV), .FAST_DIV(FDIV), .CGB_MODE(1), .SYNC_STAGES(2)) u_cgb (
        .clk(clk), .rst(rst), .a(a), .dout(dout_c), .din(din), .rd(rd), .wr(wr_c),
        .int_serial_req(req_c), .int_serial_ack(ack_c), .sck_in(1'b1),
        .sck_out(sck_out_c), .sck_oe(sck_oe_c), .sin(sin_c), .sout(sout_c));

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Write lands on the posedge between the two negedges; t0 = that edge's number.
    task automatic wr_bus(input bit sel, input logic [15:0] addr, input logic [7:0] data);
        @(negedge clk);
        a = addr; din = data;
        if (sel) wr_c = 1'b1; else wr_n = 1'b1;
        @(negedge clk);
        wr_n = 1'b0; wr_c = 1'b0;
        t0 = cyc;
    endtask

    task automatic rd_chk(input bit sel, input logic [15:0] addr, input logic [7:0] exp,
                          input string tag);
        a = addr; rd = 1'b1;
        #1;
        chk(tag, sel ? dout_c : dout_n, exp);
        rd = 1'b0;
    endtask

    task automatic ack_pulse(input bit sel);
        @(negedge clk);
        if (sel) ack_c = 1'b1; else ack_n = 1'b1;
        @(negedge clk);
        ack_n = 1'b0; ack_c = 1'b0;
        chk("req_after_ack", sel ? req_c : req_n, 0);
    endtask

    // Internal-clock transfer: tx goes out MSB first, rx (or tx when looped) comes back.
    task automatic run_int(input logic [7:0] tx, input logic [7:0] rx, input bit lp);
        logic [7:0] got;
        logic       prev;
        int         k;
        loopb = lp; sin_drv = 1'b1;
        wr_bus(0, 16'hFF01, tx);
        wr_bus(0, 16'hFF02, 8'h81);
        got = 8'h00; k = 0; prev = sck_out_n;
        for (int c = 0; c < 20 * DIV && !req_n; c++) begin
            @(negedge clk);
            if (prev && !sck_out_n) begin
                got = {got[6:0], sout_n};
                if (k < 8) sin_drv = rx[7-k];
                k++;
            end
            prev = sck_out_n;
        end
        chk("int_req_rise", req_n, 1);
        chk("int_req_latency", cyc - t0, 1 + 7 * DIV + DIV / 2);
        chk("int_fall_count", k, 8);
        chk("int_sout_seq", got, tx);
        rd_chk(0, 16'hFF01, lp ? tx : rx, "int_sb_final");
        rd_chk(0, 16'hFF02, 8'h7F, "int_sc_final");
        chk("int_sck_idle", sck_out_n, 1);
        chk("int_sout_hold", sout_n, tx[0]);
        ack_pulse(0);
        loopb = 1'b0;
    endtask

    task automatic ext_pulses(input logic [7:0] rx, input int n);
        for (int i = 0; i < n; i++) begin
            sin_drv = rx[7-i];
            sck_in_n = 1'b0;
            repeat (10) @(negedge clk);
            chk("ext_sck_out_high", sck_out_n, 1);
            sck_in_n = 1'b1;
            repeat (10) @(negedge clk);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        logic [7:0] tx, rx;
        int         rises;
        logic       prev;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_chk(0, 16'hFF01, 8'h00, "rst_sb");
        rd_chk(0, 16'hFF02, 8'h7E, "rst_sc");
        rd_chk(0, 16'hFF00, 8'hFF, "rst_unmapped");
        rd_chk(1, 16'hFF02, 8'h7C, "rst_sc_cgb");
        chk("rst_sck_out", sck_out_n, 1);
        chk("rst_sout", sout_n, 1);
        chk("rst_req", req_n, 0);

        run_int(8'hA5, 8'h00, 1'b1);
        run_int(8'hA5, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tx = 8'($urandom); rx = 8'($urandom);
            run_int(tx, rx, 1'b0);
        end

        // CGB instance: fast and normal speed, sin held high
        for (int s = 1; s >= 0; s--) begin
            wr_bus(1, 16'hFF01, 8'($urandom));
            wr_bus(1, 16'hFF02, (s == 1) ? 8'h83 : 8'h81);
            for (int c = 0; c < 20 * DIV && !req_c; c++) @(negedge clk);
            chk("cgb_req_rise", req_c, 1);
            chk("cgb_req_latency", cyc - t0,
                (s == 1) ? (1 + 7 * FDIV + FDIV / 2) : (1 + 7 * DIV + DIV / 2));
            rd_chk(1, 16'hFF01, 8'hFF, "cgb_sb_final");
            rd_chk(1, 16'hFF02, (s == 1) ? 8'h7F : 8'h7D, "cgb_sc_final");
            ack_pulse(1);
        end

        // External clock: full byte, then a short transfer that must stall
        rx = 8'($urandom);
        wr_bus(0, 16'hFF02, 8'h80);
        chk("ext_sck_oe", sck_oe_n, 0);
        ext_pulses(rx, 8);
        chk("ext_req", req_n, 1);
        rd_chk(0, 16'hFF01, rx, "ext_sb");
        rd_chk(0, 16'hFF02, 8'h7E, "ext_sc_done");
        ack_pulse(0);
        sin_drv = 1'b1;
        rx = 8'hFF;
        wr_bus(0, 16'hFF01, 8'h00);
        wr_bus(0, 16'hFF02, 8'h80);
        ext_pulses(rx, 7);
        repeat (50) @(negedge clk);
        chk("ext7_no_req", req_n, 0);
        rd_chk(0, 16'hFF02, 8'hFE, "ext7_sc_busy");
        rd_chk(0, 16'hFF01, 8'h7F, "ext7_sb_partial");
        wr_bus(0, 16'hFF02, 8'h00);
        rd_chk(0, 16'hFF02, 8'h7E, "ext7_sc_aborted");

        // Abort an internal transfer after three rising SCK edges
        wr_bus(0, 16'hFF01, 8'h5A);
        wr_bus(0, 16'hFF02, 8'h81);
        rises = 0; prev = sck_out_n;
        for (int c = 0; c < 20 * DIV && rises < 3; c++) begin
            @(negedge clk);
            if (!prev && sck_out_n) rises++;
            prev = sck_out_n;
        end
        chk("abort_rises_seen", rises, 3);
        wr_bus(0, 16'hFF02, 8'h01);
        chk("abort_sck_high", sck_out_n, 1);
        repeat (10 * DIV) @(negedge clk);
        chk("abort_no_req", req_n, 0);
        chk("abort_sck_idle", sck_out_n, 1);
        rd_chk(0, 16'hFF02, 8'h7F, "abort_sc");

        // Ack on the completion edge: completion must win
        loopb = 1'b1;
        wr_bus(0, 16'hFF01, 8'($urandom));
        wr_bus(0, 16'hFF02, 8'h81);
        repeat (7 * DIV + DIV / 2) @(negedge clk);
        chk("coinc_req_before", req_n, 0);
        ack_n = 1'b1;
        @(negedge clk);
        ack_n = 1'b0;
        chk("coinc_req_kept", req_n, 1);
        chk("coinc_latency", cyc - t0, 1 + 7 * DIV + DIV / 2);
        ack_pulse(0);
        loopb = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
